// File: rtl/lsu_store_buffered.sv
// Per-thread load/store unit: stores retire into a FIFO store buffer that drains to memory in the background.
// Optional macro STORE_FORWARD_EN lets loads forward from the youngest matching buffered store.
module lsu_store_buffered #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int SB_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 sb_empty,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready
);

    localparam int PTR_BITS = $clog2(SB_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        DONE       = 2'd3
    } lsu_state_t;

    lsu_state_t state, state_next;

    logic                 op_store;
    logic [ADDR_BITS-1:0] op_addr;
    logic [DATA_BITS-1:0] op_data;

    logic [ADDR_BITS-1:0] sb_addr [SB_DEPTH];
    logic [DATA_BITS-1:0] sb_data [SB_DEPTH];
    logic [PTR_BITS-1:0]  rd_ptr, wr_ptr;
    logic [CNT_BITS-1:0]  count;

    logic sb_full, pop, slot_free;
    logic start_op, push, issue_read, load_done, load_pending, take_fwd, start_drain;
    logic                 fwd_hit;
    logic [DATA_BITS-1:0] fwd_data;

    assign sb_full   = (count == CNT_BITS'(SB_DEPTH));
    assign pop       = mem_write_valid && mem_write_ready;
    assign slot_free = !sb_full || pop;
    assign sb_empty  = (count == '0) && !mem_write_valid;
    assign lsu_state = state;

`ifdef STORE_FORWARD_EN
    // Oldest-to-youngest scan so the last match wins; the in-flight head is still a valid entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (CNT_BITS'(i) < count && sb_addr[rd_ptr + PTR_BITS'(i)] == op_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[rd_ptr + PTR_BITS'(i)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        start_op     = 1'b0;
        push         = 1'b0;
        issue_read   = 1'b0;
        load_done    = 1'b0;
        load_pending = 1'b0;
        take_fwd     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && core_state == CORE_REQUEST &&
                    (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    start_op   = 1'b1;
                    state_next = REQUESTING;
                end
            end
            REQUESTING: begin
                if (op_store) begin
                    if (slot_free) begin
                        push       = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = WAITING;
                    end
                end else if (fwd_hit) begin
                    take_fwd   = 1'b1;
                    state_next = DONE;
                end else begin
`ifdef STORE_FORWARD_EN
                    load_pending = 1'b1;
                    if (!mem_write_valid) begin
`else
                    load_pending = sb_empty;
                    if (sb_empty) begin
`endif
                        issue_read = 1'b1;
                        state_next = WAITING;
                    end
                end
            end
            WAITING: begin
                if (op_store) begin
                    if (slot_free) begin
                        push       = 1'b1;
                        state_next = DONE;
                    end
                end else if (mem_read_valid && mem_read_ready) begin
                    load_done  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (core_state == CORE_UPDATE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A pending load read outranks starting a new drain; an in-flight write is never abandoned.
    assign start_drain = !mem_write_valid && (count != '0) && !mem_read_valid && !load_pending;

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[wr_ptr] <= op_addr;
            sb_data[wr_ptr] <= op_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_store          <= 1'b0;
            op_addr           <= '0;
            op_data           <= '0;
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            lsu_out           <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            if (start_op) begin
                op_store <= decoded_mem_write_enable;
                op_addr  <= rs[ADDR_BITS-1:0];
                op_data  <= rt;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                mem_write_valid <= 1'b0;
            end else if (start_drain) begin
                mem_write_valid   <= 1'b1;
                mem_write_address <= sb_addr[rd_ptr];
                mem_write_data    <= sb_data[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (issue_read) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= op_addr;
            end
            if (load_done) begin
                mem_read_valid <= 1'b0;
                lsu_out        <= mem_read_data;
            end
            if (take_fwd) lsu_out <= fwd_data;
        end
    end

endmodule

// File: tb/tb_lsu_store_buffered.sv
// Scoreboard bench for lsu_store_buffered: a driver issues LDR/STR, responders emulate the memory controller,
// and a monitor compares drained writes and load results against an architectural memory model.
module tb_lsu_store_buffered;

    localparam logic [2:0] CS_REQUEST = 3'b011;
    localparam logic [2:0] CS_UPDATE  = 3'b110;
    localparam logic [2:0] CS_OTHER   = 3'b100;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic       decoded_mem_read_enable;
    logic       decoded_mem_write_enable;
    logic [7:0] rs, rt;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       sb_empty;
    logic       mem_read_valid;
    logic [7:0] mem_read_address;
    logic       mem_read_ready = 1'b0;
    logic [7:0] mem_read_data = 8'h00;
    logic       mem_write_valid;
    logic [7:0] mem_write_address;
    logic [7:0] mem_write_data;
    logic       mem_write_ready = 1'b0;

    always #5 clk = ~clk;

    lsu_store_buffered #(.ADDR_BITS(8), .DATA_BITS(8), .SB_DEPTH(4)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .rs                       (rs),
        .rt                       (rt),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .sb_empty                 (sb_empty),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready)
    );

    int nchecks = 0;
    int nfails  = 0;
    int cycle   = 0;

    logic [7:0] dram [256];
    logic [7:0] arch [256];
    wr_t        exp_writes [$];
    logic [7:0] exp_loads [$];
    wr_t        mon_e;
    logic [7:0] mon_l;

    bit wr_stall = 1'b0;
    int wr_delay = 0;
    int rd_delay = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    bit cur_is_load = 1'b0;

    int reads_issued    = 0;
    int writes_acked    = 0;
    int first_ack_cycle = -1;
    int pend_at_read    = 0;
    int overlap_viol    = 0;
    int hold_viol       = 0;
    int raw_viol        = 0;

    logic       prev_wv = 1'b0, prev_wr = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
    logic [7:0] prev_wa = 8'h00, prev_wd = 8'h00, prev_ra = 8'h00;
    logic [1:0] prev_state = 2'd0;

    int lat, dc, r0, w0, n;
    int lat5, dc5;
    bit fifth_done;
    bit is_store, both;
    logic [7:0] addr, data;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nchecks++;
        if (actual !== expected) begin
            nfails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write side of the memory controller: optional stall, then a one-cycle ready pulse after wr_delay cycles.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mem_write_ready = 1'b0;
            wr_cnt = 0;
        end else if (mem_write_ready) begin
            mem_write_ready = 1'b0;
        end else if (mem_write_valid && !wr_stall) begin
            if (wr_cnt >= wr_delay) begin
                mem_write_ready = 1'b1;
                wr_cnt = 0;
            end else begin
                wr_cnt++;
            end
        end
    end

    // Read side: data is garbage except in the ready cycle, so a mistimed capture shows up.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            mem_read_ready = 1'b0;
            rd_cnt = 0;
        end else if (mem_read_ready) begin
            mem_read_ready = 1'b0;
            mem_read_data  = 8'($urandom);
        end else if (mem_read_valid) begin
            if (rd_cnt >= rd_delay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = dram[mem_read_address];
                rd_cnt = 0;
            end else begin
                rd_cnt++;
            end
        end
    end

    // Monitor: pops expectations on each completed write and each load reaching DONE, and tracks protocol rules.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            prev_wv    = 1'b0;
            prev_rv    = 1'b0;
            prev_state = 2'd0;
        end else begin
            if (mem_read_valid && mem_write_valid) overlap_viol++;
            if (prev_wv && !prev_wr &&
                !(mem_write_valid && mem_write_address == prev_wa && mem_write_data == prev_wd)) hold_viol++;
            if (prev_rv && !prev_rr && !(mem_read_valid && mem_read_address == prev_ra)) hold_viol++;
            if (mem_write_valid && mem_write_ready) begin
                if (exp_writes.size() == 0) begin
                    checkOutput("unexpected_write", 32'(mem_write_address), 32'hFFFF);
                end else begin
                    mon_e = exp_writes.pop_front();
                    checkOutput("write_addr", 32'(mem_write_address), 32'(mon_e.addr));
                    checkOutput("write_data", 32'(mem_write_data), 32'(mon_e.data));
                end
                dram[mem_write_address] = mem_write_data;
                writes_acked++;
                if (first_ack_cycle < 0) first_ack_cycle = cycle;
            end
            if (mem_read_valid && !prev_rv) begin
                reads_issued++;
                pend_at_read = exp_writes.size();
`ifndef STORE_FORWARD_EN
                if (exp_writes.size() != 0) raw_viol++;
`endif
            end
            if (lsu_state == 2'd3 && prev_state != 2'd3 && cur_is_load) begin
                if (exp_loads.size() == 0) begin
                    checkOutput("unexpected_load", 32'(lsu_out), 32'hFFFF);
                end else begin
                    mon_l = exp_loads.pop_front();
                    checkOutput("load_data", 32'(lsu_out), 32'(mon_l));
                end
            end
            prev_wv    = mem_write_valid;
            prev_wr    = mem_write_ready;
            prev_wa    = mem_write_address;
            prev_wd    = mem_write_data;
            prev_rv    = mem_read_valid;
            prev_rr    = mem_read_ready;
            prev_ra    = mem_read_address;
            prev_state = lsu_state;
        end
    end

    // Issues one op; the expected outcome comes from program-order architectural memory.
    task automatic applyStimulus(input bit st, input bit both_en, input logic [7:0] a, input logic [7:0] d,
                                 output int latency, output int done_cycle);
        int k;
        @(negedge clk);
        core_state               = CS_REQUEST;
        decoded_mem_write_enable = st;
        decoded_mem_read_enable  = !st || both_en;
        rs = a;
        rt = d;
        if (st) begin
            exp_writes.push_back(wr_t'{a, d});
            arch[a] = d;
        end else begin
            exp_loads.push_back(arch[a]);
            cur_is_load = 1'b1;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
            core_state = CS_OTHER;
        end while (lsu_state != 2'd3 && k < 300);
        latency    = k;
        done_cycle = cycle;
        if (lsu_state != 2'd3) checkOutput("op_done_timeout", 32'(lsu_state), 32'd3);
        core_state = CS_UPDATE;
        @(negedge clk);
        core_state               = CS_OTHER;
        decoded_mem_write_enable = 1'b0;
        decoded_mem_read_enable  = 1'b0;
        cur_is_load              = 1'b0;
    endtask

    task automatic waitDrain();
        int k = 0;
        while (!(sb_empty && exp_writes.size() == 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain_done", 32'(sb_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        core_state = 3'b000;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        rs = 8'h00;
        rt = 8'h00;
        for (int i = 0; i < 256; i++) begin
            dram[i] = 8'($urandom);
            arch[i] = dram[i];
        end
        dram[8'h20] = 8'h5A;
        arch[8'h20] = 8'h5A;
        repeat (3) @(negedge clk);
        checkOutput("reset_lsu_state", 32'(lsu_state), 32'd0);
        checkOutput("reset_lsu_out", 32'(lsu_out), 32'd0);
        checkOutput("reset_sb_empty", 32'(sb_empty), 32'd1);
        checkOutput("reset_read_valid", 32'(mem_read_valid), 32'd0);
        checkOutput("reset_write_valid", 32'(mem_write_valid), 32'd0);
        checkOutput("reset_write_addr", 32'(mem_write_address), 32'd0);
        reset = 1'b0;

        $display("[TB] reset in the middle of a drain");
        wr_stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h60, 8'h77, lat, dc);
        n = 0;
        while (!mem_write_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_started", 32'(mem_write_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_write_valid", 32'(mem_write_valid), 32'd0);
        checkOutput("rst_mid_sb_empty", 32'(sb_empty), 32'd1);
        checkOutput("rst_mid_lsu_state", 32'(lsu_state), 32'd0);
        reset = 1'b0;
        exp_writes.delete();
        exp_loads.delete();
        for (int i = 0; i < 256; i++) arch[i] = dram[i];
        wr_stall = 1'b0;

        $display("[TB] single store with slow write ack");
        wr_delay = 3;
        w0 = writes_acked;
        applyStimulus(1'b1, 1'b0, 8'h10, 8'hAA, lat, dc);
        checkOutput("store_latency", 32'(lat), 32'd2);
        waitDrain();
        checkOutput("single_write_count", 32'(writes_acked), 32'(w0 + 1));

        $display("[TB] store buffer full");
        wr_stall = 1'b1;
        wr_delay = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'h40 + 8'(i), 8'hC0 + 8'(i), lat, dc);
            checkOutput("fill_latency", 32'(lat), 32'd2);
        end
        first_ack_cycle = -1;
        fifth_done = 1'b0;
        fork
            begin
                applyStimulus(1'b1, 1'b0, 8'h44, 8'hC4, lat5, dc5);
                fifth_done = 1'b1;
            end
        join_none
        repeat (6) @(negedge clk);
        checkOutput("fifth_waiting", 32'(lsu_state), 32'd2);
        wr_stall = 1'b0;
        n = 0;
        while (!fifth_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fifth_completed", 32'(fifth_done), 32'd1);
        checkOutput("fifth_push_on_ack", 32'(dc5), 32'(first_ack_cycle + 1));
        waitDrain();

        $display("[TB] store then load to the same address");
        wr_delay = 3;
        rd_delay = 1;
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h11, lat, dc);
        applyStimulus(1'b0, 1'b0, 8'h20, 8'h00, lat, dc);
        waitDrain();

        $display("[TB] two stores then load, youngest wins");
`ifdef STORE_FORWARD_EN
        wr_stall = 1'b1;
`endif
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h33, lat, dc);
        applyStimulus(1'b1, 1'b0, 8'h20, 8'h44, lat, dc);
        r0 = reads_issued;
        applyStimulus(1'b0, 1'b0, 8'h20, 8'h00, lat, dc);
`ifdef STORE_FORWARD_EN
        checkOutput("fwd_latency", 32'(lat), 32'd2);
        checkOutput("fwd_no_read", 32'(reads_issued), 32'(r0));
        wr_stall = 1'b0;
`else
        checkOutput("load_read_count", 32'(reads_issued), 32'(r0 + 1));
`endif
        waitDrain();

        $display("[TB] load competing with a busy drain");
        wr_delay = 6;
        rd_delay = 1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h70 + 8'(i), 8'h90 + 8'(i), lat, dc);
        r0 = reads_issued;
        applyStimulus(1'b0, 1'b0, 8'h30, 8'h00, lat, dc);
        checkOutput("miss_read_issued", 32'(reads_issued), 32'(r0 + 1));
`ifdef STORE_FORWARD_EN
        checkOutput("load_before_drain", 32'(pend_at_read > 0), 32'd1);
`endif
        waitDrain();

        $display("[TB] enable low blocks new ops");
        enable = 1'b0;
        @(negedge clk);
        core_state = CS_REQUEST;
        decoded_mem_read_enable = 1'b1;
        rs = 8'h30;
        repeat (3) @(negedge clk);
        checkOutput("disabled_idle", 32'(lsu_state), 32'd0);
        core_state = CS_OTHER;
        decoded_mem_read_enable = 1'b0;
        enable = 1'b1;

        $display("[TB] randomized op mix");
        for (int i = 0; i < 40; i++) begin
            wr_delay = $urandom_range(0, 3);
            rd_delay = $urandom_range(0, 3);
            is_store = 1'($urandom_range(0, 1));
            both     = is_store && ($urandom_range(0, 3) == 0);
            addr     = 8'h50 + 8'($urandom_range(0, 3));
            data     = 8'($urandom);
            applyStimulus(is_store, both, addr, data, lat, dc);
        end
        waitDrain();

        checkOutput("no_rw_overlap", 32'(overlap_viol), 32'd0);
        checkOutput("handshake_hold", 32'(hold_viol), 32'd0);
        checkOutput("raw_order", 32'(raw_viol), 32'd0);
        checkOutput("loads_all_seen", 32'(exp_loads.size()), 32'd0);
        checkOutput("writes_all_seen", 32'(exp_writes.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
